// File: rtl/triangle_wave_sequencer_if.sv
// Control/config/status bundle between register logic and the
// triangle_wave segment sequencer.
interface triangle_wave_sequencer_if #(
  parameter int WIDTH     = 4,
  parameter int SEG_BITS  = 2,
  parameter int DUR_WIDTH = 16
);
  logic                 cfg_we;
  logic [SEG_BITS-1:0]  cfg_addr;
  logic [WIDTH-1:0]     cfg_low;
  logic [WIDTH-1:0]     cfg_high;
  logic [DUR_WIDTH-1:0] cfg_dur;
  logic [SEG_BITS-1:0]  last_seg;
  logic                 loop;
  logic                 start;
  logic                 stop;
  logic                 wave_enable;
  logic [WIDTH-1:0]     low_out;
  logic [WIDTH-1:0]     high_out;
  logic [SEG_BITS-1:0]  seg_idx;
  logic                 busy;
  logic                 done;

  modport master (
    output cfg_we, cfg_addr, cfg_low, cfg_high, cfg_dur,
    output last_seg, loop, start, stop,
    input  wave_enable, low_out, high_out, seg_idx, busy, done
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_low, cfg_high, cfg_dur,
    input  last_seg, loop, start, stop,
    output wave_enable, low_out, high_out, seg_idx, busy, done
  );
endinterface

// File: rtl/triangle_wave_sequencer.sv
// Plays a small table of (low, high, duration) segments into a
// triangle_wave instance, once or looping, then parks it.
module triangle_wave_sequencer #(
  parameter int WIDTH     = 4,
  parameter int SEG_BITS  = 2,
  parameter int DUR_WIDTH = 16
) (
  input  logic clk,
  input  logic rst_n,
  triangle_wave_sequencer_if.slave bus
);
  localparam int DEPTH = 1 << SEG_BITS;
  localparam logic [DUR_WIDTH-1:0] DUR_ONE = DUR_WIDTH'(1);
  localparam logic [SEG_BITS-1:0]  SEG_ONE = SEG_BITS'(1);

  typedef enum logic { IDLE, RUN } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0]     low_tbl  [DEPTH];
  logic [WIDTH-1:0]     high_tbl [DEPTH];
  logic [DUR_WIDTH-1:0] dur_tbl  [DEPTH];

  logic [DUR_WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0]     low_q;
  logic [WIDTH-1:0]     high_q;
  logic [SEG_BITS-1:0]  seg_q;
  logic                 done_q;
  logic                 done_d;

  logic                 load;
  logic [SEG_BITS-1:0]  load_idx;
  logic [WIDTH-1:0]     rd_low;
  logic [WIDTH-1:0]     rd_high;
  logic [DUR_WIDTH-1:0] rd_dur;
  logic [WIDTH-1:0]     ld_low;
  logic [WIDTH-1:0]     ld_high;
  logic [DUR_WIDTH-1:0] ld_dur;

  // Entry being loaded: bounds ordered, zero duration treated as one
  assign rd_low  = low_tbl[load_idx];
  assign rd_high = high_tbl[load_idx];
  assign rd_dur  = dur_tbl[load_idx];
  assign ld_low  = (rd_low <= rd_high) ? rd_low  : rd_high;
  assign ld_high = (rd_low <= rd_high) ? rd_high : rd_low;
  assign ld_dur  = (rd_dur == '0) ? DUR_ONE : rd_dur;

  // Segment table; a write only affects later loads of that entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        low_tbl[i]  <= '0;
        high_tbl[i] <= '1;
        dur_tbl[i]  <= DUR_ONE;
      end
    end else if (bus.cfg_we) begin
      low_tbl[bus.cfg_addr]  <= bus.cfg_low;
      high_tbl[bus.cfg_addr] <= bus.cfg_high;
      dur_tbl[bus.cfg_addr]  <= bus.cfg_dur;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state and segment-boundary decisions; stop wins over all
  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    load_idx = '0;
    done_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start && !bus.stop) begin
          state_d = RUN;
          load    = 1'b1;
        end
      end
      RUN: begin
        if (bus.stop) begin
          state_d = IDLE;
        end else if (cnt_q <= DUR_ONE) begin
          if (seg_q != bus.last_seg) begin
            load     = 1'b1;
            load_idx = seg_q + SEG_ONE;
          end else if (bus.loop) begin
            load = 1'b1;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Registered segment outputs and duration counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      low_q  <= '0;
      high_q <= '1;
      seg_q  <= '0;
      cnt_q  <= DUR_ONE;
      done_q <= 1'b0;
    end else begin
      done_q <= done_d;
      if (load) begin
        low_q  <= ld_low;
        high_q <= ld_high;
        seg_q  <= load_idx;
        cnt_q  <= ld_dur;
      end else if (state_q == RUN) begin
        cnt_q <= cnt_q - DUR_ONE;
      end
    end
  end

  assign bus.wave_enable = (state_q == RUN);
  assign bus.busy        = (state_q == RUN);
  assign bus.low_out     = low_q;
  assign bus.high_out    = high_q;
  assign bus.seg_idx     = seg_q;
  assign bus.done        = done_q;
endmodule

// File: tb/tb_triangle_wave_sequencer.sv
// Randomized scoreboard bench for triangle_wave_sequencer against
// a cycle-level behavioural model of the segment player.
module tb_triangle_wave_sequencer;
  localparam int W  = 4;
  localparam int SB = 2;
  localparam int DW = 16;
  localparam int N  = 1 << SB;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  triangle_wave_sequencer_if #(.WIDTH(W), .SEG_BITS(SB), .DUR_WIDTH(DW)) bus ();

  triangle_wave_sequencer #(.WIDTH(W), .SEG_BITS(SB), .DUR_WIDTH(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int en;
    int lo;
    int hi;
    int idx;
    int done;
  } exp_t;

  exp_t expq[$];
  int n_chk = 0;
  int n_fail = 0;

  int m_lo[N];
  int m_hi[N];
  int m_du[N];
  int m_run, m_idx, m_rem, m_low, m_high, m_done;

  task automatic chk(string name, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_lo[i] = 0;
      m_hi[i] = (1 << W) - 1;
      m_du[i] = 1;
    end
    m_run = 0; m_idx = 0; m_rem = 1;
    m_low = 0; m_high = (1 << W) - 1; m_done = 0;
  endtask

  task automatic model_load(int k);
    int a, b;
    a = m_lo[k];
    b = m_hi[k];
    m_low  = (a < b) ? a : b;
    m_high = (a < b) ? b : a;
    m_rem  = (m_du[k] == 0) ? 1 : m_du[k];
    m_idx  = k;
  endtask

  // Applies the sequencing rules to the inputs present at the coming edge
  task automatic model_step();
    exp_t e;
    m_done = 0;
    if (m_run == 0) begin
      if (bus.start && !bus.stop) begin
        m_run = 1;
        model_load(0);
      end
    end else if (bus.stop) begin
      m_run = 0;
    end else if (m_rem > 1) begin
      m_rem--;
    end else if (m_idx != int'(bus.last_seg)) begin
      model_load((m_idx + 1) % N);
    end else if (bus.loop) begin
      model_load(0);
    end else begin
      m_run = 0;
      m_done = 1;
    end
    if (bus.cfg_we) begin
      m_lo[bus.cfg_addr] = int'(bus.cfg_low);
      m_hi[bus.cfg_addr] = int'(bus.cfg_high);
      m_du[bus.cfg_addr] = int'(bus.cfg_dur);
    end
    e.en = m_run; e.lo = m_low; e.hi = m_high;
    e.idx = m_idx; e.done = m_done;
    expq.push_back(e);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wr(int a, int l, int h, int d);
    bus.cfg_we   = 1'b1;
    bus.cfg_addr = SB'(a);
    bus.cfg_low  = W'(l);
    bus.cfg_high = W'(h);
    bus.cfg_dur  = DW'(d);
    tick();
    bus.cfg_we = 1'b0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic chk_reset_vals(string tag);
    chk({tag, "_wave_enable"}, int'(bus.wave_enable), 0);
    chk({tag, "_low_out"}, int'(bus.low_out), 0);
    chk({tag, "_high_out"}, int'(bus.high_out), (1 << W) - 1);
    chk({tag, "_seg_idx"}, int'(bus.seg_idx), 0);
    chk({tag, "_busy"}, int'(bus.busy), 0);
    chk({tag, "_done"}, int'(bus.done), 0);
  endtask

  // Monitor: pops one expectation per cycle once the DUT has settled
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && expq.size() > 0) begin
        e = expq.pop_front();
        chk("wave_enable", int'(bus.wave_enable), e.en);
        chk("busy", int'(bus.busy), e.en);
        chk("low_out", int'(bus.low_out), e.lo);
        chk("high_out", int'(bus.high_out), e.hi);
        chk("seg_idx", int'(bus.seg_idx), e.idx);
        chk("done", int'(bus.done), e.done);
        chk("low_le_high", int'(bus.low_out <= bus.high_out), 1);
      end
    end
  end

  initial begin
    int guard;
    bus.cfg_we = 0; bus.cfg_addr = 0; bus.cfg_low = 0;
    bus.cfg_high = 0; bus.cfg_dur = 0; bus.last_seg = 0;
    bus.loop = 0; bus.start = 0; bus.stop = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("por");
    @(negedge clk);
    rst_n = 1'b1;

    // Three-segment one-shot, 20 cycles each
    wr(0, 0, 13, 20);
    wr(1, 5, 13, 20);
    wr(2, 5, 10, 20);
    bus.last_seg = 2; bus.loop = 0;
    pulse_start();
    ticks(65);

    // Looping two segments, second with zero duration
    wr(0, 0, 13, 3);
    wr(1, 2, 4, 0);
    bus.last_seg = 1; bus.loop = 1;
    pulse_start();
    ticks(20);
    bus.stop = 1; tick(); bus.stop = 0;

    // Swapped bounds are reordered on load
    wr(0, 12, 3, 5);
    bus.last_seg = 0; bus.loop = 0;
    pulse_start();
    ticks(7);

    // Write to the active segment plus start while running
    wr(0, 0, 13, 3);
    wr(1, 2, 4, 6);
    bus.last_seg = 1; bus.loop = 1;
    pulse_start();
    guard = 0;
    while (m_idx != 1 && guard < 20) begin
      tick();
      guard++;
    end
    chk("reach_seg1", m_idx, 1);
    bus.start = 1'b1;
    wr(1, 2, 9, 6);
    bus.start = 1'b0;
    ticks(20);
    bus.stop = 1; tick(); bus.stop = 0;

    // Stop coinciding with natural expiry of the last segment
    wr(0, 1, 2, 2);
    wr(1, 3, 4, 3);
    bus.loop = 0;
    pulse_start();
    guard = 0;
    while (!(m_run == 1 && m_idx == 1 && m_rem == 1) && guard < 20) begin
      tick();
      guard++;
    end
    chk("reach_expiry", m_rem, 1);
    bus.stop = 1; tick();
    bus.start = 1; tick();
    bus.start = 0; bus.stop = 0;
    ticks(3);

    // Randomized writes, starts, stops and run-time control changes
    for (int i = 0; i < 1500; i++) begin
      bus.cfg_we   = ($urandom_range(7) == 0);
      bus.cfg_addr = SB'($urandom_range(N - 1));
      bus.cfg_low  = W'($urandom);
      bus.cfg_high = W'($urandom);
      bus.cfg_dur  = DW'($urandom_range(6));
      bus.start    = ($urandom_range(9) == 0);
      bus.stop     = ($urandom_range(39) == 0);
      if ($urandom_range(49) == 0) begin
        bus.last_seg = SB'($urandom_range(N - 1));
        bus.loop     = $urandom_range(1) == 1;
      end
      tick();
    end
    bus.cfg_we = 0; bus.start = 0; bus.stop = 0;
    bus.stop = 1; tick(); bus.stop = 0;

    // Asynchronous reset in the middle of a segment
    wr(0, 4, 9, 10);
    bus.last_seg = 0; bus.loop = 1;
    pulse_start();
    ticks(4);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("async_rst");
    model_reset();
    @(posedge clk);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    bus.loop = 0;
    pulse_start();
    ticks(4);

    @(negedge clk);
    #1;
    chk("queue_drained", expq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/triangle_wave_sequencer.md
# triangle_wave_sequencer

Programmable segment sequencer that drives the `enable`, `low_in` and `high_in` inputs of a `triangle_wave` instance. A small register table holds up to 2^SEG_BITS segments, each with a low bound, a high bound and a duration in clock cycles. On `start` the block plays the segments in order, once or looping, and then parks the generator. It sits between the control/register logic and the `triangle_wave` datapath, and replaces hand-timed bound changes.

## Interface
- `WIDTH`, 4: amplitude width; must match the `triangle_wave` parameter.
- `SEG_BITS`, 2: segment index width; table depth is 2^SEG_BITS.
- `DUR_WIDTH`, 16: segment duration counter width.

- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low. One clock, no other resets.
- `cfg_we`  in  1  table write strobe.
- `cfg_addr`  in  SEG_BITS  table entry to write.
- `cfg_low`  in  WIDTH  low bound to write.
- `cfg_high`  in  WIDTH  high bound to write.
- `cfg_dur`  in  DUR_WIDTH  duration in cycles to write.
- `last_seg`  in  SEG_BITS  index of the final segment played.
- `loop`  in  1  1 = wrap to segment 0 after `last_seg`.
- `start`  in  1  start pulse, level-sampled.
- `stop`  in  1  abort pulse, level-sampled.
- `wave_enable`  out  1  connects to `triangle_wave.enable`.
- `low_out`  out  WIDTH  connects to `low_in`.
- `high_out`  out  WIDTH  connects to `high_in`.
- `seg_idx`  out  SEG_BITS  index of the active segment.
- `busy`  out  1  sequence running.
- `done`  out  1  one-cycle pulse on natural completion.

## Operation
- Table entries reset to low=0, high=all-ones, dur=1.
- Writes happen when `cfg_we`=1 and are allowed in any state. A write changes an entry only for later loads of that entry. The outputs of the segment currently playing never change mid-segment.
- Effective duration is `max(dur,1)`, so dur=0 behaves as 1 cycle.
- Segment load: `low_out`=min(low,high) and `high_out`=max(low,high). This guarantees `low_out`<=`high_out`.
- FSM has two states, IDLE and RUN.
  - IDLE: `wave_enable`=0 and `busy`=0. `low_out`, `high_out` and `seg_idx` keep their last values.
  - IDLE → RUN: `start`=1 and `stop`=0. Load segment 0 and set the duration counter.
  - RUN: the counter decrements each cycle. When it expires, one of three things happens:
    - if `seg_idx`≠`last_seg`: load `seg_idx`+1;
    - else if `loop`=1: load segment 0;
    - else: go to IDLE and pulse `done`.
  - RUN → IDLE on `stop`=1, with no `done` pulse. `stop` has priority over expiry and over `start`.
  - `start` is ignored while in RUN (no restart).
- `last_seg` and `loop` are sampled at each segment boundary, so changing them mid-run takes effect at the next boundary.
- `last_seg`=0 with `loop`=1 replays segment 0 continuously, reloading it at each boundary.
- Reset mid-run forces the reset state immediately: `wave_enable`=0, table back to defaults.

## Timing
- Reset values: `wave_enable`=0, `low_out`=0, `high_out`=all-ones, `seg_idx`=0, `busy`=0, `done`=0.
- All outputs are registered. There are no combinational input-to-output paths.
- `start` sampled high at edge T: from edge T+1, `busy`=1, `wave_enable`=1, `seg_idx`=0, and the bounds are segment 0's.
- Segment k is presented for exactly `max(dur_k,1)` cycles. `low_out`, `high_out` and `seg_idx` update on the same edge, with no idle cycle between segments.
- Natural completion: `wave_enable`, `busy`→0 and `done`=1 all occur in the same cycle, immediately after the last segment's final cycle. `done` lasts one cycle.
- `stop` sampled at edge T: `wave_enable`=0 and `busy`=0 from edge T+1.
- `cfg_we` at edge T to a not-active entry: it is visible if that entry is loaded at edge T+1 or later.

## Test plan
- Reset, then program seg0 = (0,13,20), seg1 = (5,13,20), seg2 = (5,10,20); `last_seg`=2, `loop`=0; pulse `start`.
  - Required: bounds (0,13), then (5,13), then (5,10), 20 cycles each.
  - `done` pulses at cycle 61 after start, and `wave_enable` drops in that same cycle.
  - Check `triangle_wave` output stays within bounds throughout.
- `loop`=1, seg0 = (0,13,3), seg1 = (2,4,0); `last_seg`=1.
  - Required: `seg_idx` pattern 0,0,0,1,0,0,0,1…
  - `busy` stays high and `done` never pulses.
- Write seg0 = (12,3,5).
  - Required: `low_out`=3 and `high_out`=12.
- Running in seg1; write seg1's high and pulse `start`.
  - Required: no output change and no restart.
  - The new value appears on the next loop pass.
- Assert `stop` and natural expiry in the same cycle on the last segment.
  - Required: IDLE on the next edge with no `done` pulse.
  - Then `start` together with `stop`: remain IDLE.
- Assert `rst_n` low mid-segment.
  - Required: all outputs return to reset values asynchronously.
  - After release, `start` plays the default table entry (0, all-ones, 1 cycle).
